// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-lane data memory behind the LSU.
// Wait-state access FSM; stalls the core per access.
module data_mem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd_wr,
  input  logic [3:0]  mask,
  input  logic [31:0] Mem_Addr,
  input  logic [31:0] Store_Data,
  output logic [31:0] Mem_Data_Out,
  output logic        stall,
  output logic        done,
  output logic        addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_rd_wr;
  logic [3:0]  r_mask;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_launch;
  logic        w_acc;
  logic        w_rw;
  logic [3:0]  w_mask;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] w_wdat;
  logic        w_oor;
  logic [AW-1:0] w_idx;

  assign w_launch = (r_state == S_IDLE) && !cs;

  // With zero wait states the access uses the live request.
  assign w_rw   = w_launch ? rd_wr      : r_rd_wr;
  assign w_mask = w_launch ? mask       : r_mask;
  assign w_addr = w_launch ? Mem_Addr   : r_addr;
  assign w_data = w_launch ? Store_Data : r_data;

  assign w_oor  = {2'b00, w_addr[31:2]} >= 32'(DEPTH);
  assign w_idx  = w_addr[AW+1:2];
  assign w_wdat = w_data << {w_addr[1:0], 3'b000};

  assign done     = !rst && (r_state == S_RESP);
  assign addr_err = done && r_err;

  // Next state, access strobe and Mealy stall.
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    w_acc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!cs) begin
          stall = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next = S_RESP;
            w_acc  = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (r_cnt == 4'd1) begin
          w_next = S_RESP;
          w_acc  = 1'b1;
        end
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      stall = 1'b0;
      w_acc = 1'b0;
    end
  end

  // State, wait counter, request latch and read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_rd_wr      <= 1'b0;
      r_mask       <= 4'd0;
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      r_err        <= 1'b0;
      Mem_Data_Out <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_rd_wr <= rd_wr;
        r_mask  <= mask;
        r_addr  <= Mem_Addr;
        r_data  <= Store_Data;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_acc) begin
        r_err <= w_oor;
        if (w_rw) begin
          Mem_Data_Out <= w_oor ? 32'd0 : r_mem[w_idx];
        end
      end
    end
  end

  // Byte-lane store into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_acc && !w_rw && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
        end
      end
    end
  end

endmodule
